// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared FSM state and LED polarity definitions for the RGB PWM driver
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        FADE  = 2'd2
    } state_t;

    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one colour channel: target/duty registers, fade step and PWM comparator
module pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [PWM_BITS-1:0] target_in,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                apply,
    input  logic                step,
    output logic                step_done,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] target_q, target_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] step_val;
    logic                led_q, led_d;

    // Next duty: a jump copies the target, a fade step moves one LSB toward it and never past it
    always_comb begin
        target_d = load ? target_in : target_q;
        if (duty_q < target_q) begin
            step_val = duty_q + ONE;
        end else if (duty_q > target_q) begin
            step_val = duty_q - ONE;
        end else begin
            step_val = duty_q;
        end
        duty_d = duty_q;
        if (apply) begin
            duty_d = target_q;
        end else if (step) begin
            duty_d = step_val;
        end
        step_done = (step_val == target_q);
        led_d     = (pwm_cnt < duty_q) ? LED_ON : LED_OFF;
    end

    // Channel state; duty only moves when the top qualifies apply/step with a frame boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= '0;
            duty_q   <= '0;
            led_q    <= LED_OFF;
        end else begin
            target_q <= target_d;
            duty_q   <= duty_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - RGB PWM LED driver with jump/fade colour requests over valid/ready
module rgb_pwm_driver
    import led_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 4,
    parameter int FADE_FRAMES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                col_valid,
    output logic                col_ready,
    input  logic [PWM_BITS-1:0] col_r,
    input  logic [PWM_BITS-1:0] col_g,
    input  logic [PWM_BITS-1:0] col_b,
    input  logic                col_fade,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic                busy,
    output logic                frame_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [FW-1:0] FADE_MAX  = FW'(FADE_FRAMES - 1);

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [FW-1:0]       fade_cnt_q, fade_cnt_d;
    logic                frame_start_q, frame_start_d;
    logic                tick, fb, accept, fade_step, apply, step, all_done;
    logic                done_r, done_g, done_b;

    // Timebase: prescaler tick, PWM counter and the frame-boundary strobe
    always_comb begin
        tick          = (presc_q == PRESC_MAX);
        presc_d       = tick ? '0 : presc_q + PW'(1);
        pwm_cnt_d     = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        fb            = tick && (pwm_cnt_q == '1);
        frame_start_d = fb;
        accept        = col_valid && (state_q == IDLE);
        fade_step     = (state_q == FADE) && fb && (fade_cnt_q == FADE_MAX);
        all_done      = done_r && done_g && done_b;
        // Cleared on accept so every fade starts counting frames from zero
        fade_cnt_d    = fade_cnt_q;
        if (accept) begin
            fade_cnt_d = '0;
        end else if ((state_q == FADE) && fb) begin
            fade_cnt_d = fade_step ? '0 : fade_cnt_q + FW'(1);
        end
    end

    // Timebase and fade frame counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q       <= '0;
            pwm_cnt_q     <= '0;
            fade_cnt_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            pwm_cnt_q     <= pwm_cnt_d;
            fade_cnt_q    <= fade_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a boundary in the accept cycle is seen while still IDLE and so is skipped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = col_fade ? FADE : APPLY;
            APPLY:   if (fb) state_d = IDLE;
            FADE:    if (fade_step && all_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake, busy and per-boundary duty update strobes
    always_comb begin
        col_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        apply     = (state_q == APPLY) && fb;
        step      = fade_step;
    end

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_r (
        .clk(clk), .reset(reset), .load(accept), .target_in(col_r), .pwm_cnt(pwm_cnt_q),
        .apply(apply), .step(step), .step_done(done_r), .led(led_r)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_g (
        .clk(clk), .reset(reset), .load(accept), .target_in(col_g), .pwm_cnt(pwm_cnt_q),
        .apply(apply), .step(step), .step_done(done_g), .led(led_g)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_b (
        .clk(clk), .reset(reset), .load(accept), .target_in(col_b), .pwm_cnt(pwm_cnt_q),
        .apply(apply), .step(step), .step_done(done_b), .led(led_b)
    );

    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb/tb_rgb_pwm_driver.sv - self-checking bench for rgb_pwm_driver (4-bit PWM, 16-clk frames)
module tb_rgb_pwm_driver;

    localparam int PB    = 4;
    localparam int FRAME = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          col_valid = 1'b0;
    logic          col_ready;
    logic [PB-1:0] col_r = '0;
    logic [PB-1:0] col_g = '0;
    logic [PB-1:0] col_b = '0;
    logic          col_fade = 1'b0;
    logic          led_r, led_g, led_b;
    logic          busy, frame_start;

    int tests = 0;
    int fails = 0;
    int cyc;
    int md[3];

    rgb_pwm_driver #(.PWM_BITS(PB), .PRESCALE(1), .FADE_FRAMES(1)) dut (
        .clk(clk), .reset(reset), .col_valid(col_valid), .col_ready(col_ready),
        .col_r(col_r), .col_g(col_g), .col_b(col_b), .col_fade(col_fade),
        .led_r(led_r), .led_g(led_g), .led_b(led_b), .busy(busy), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; frame boundaries land on multiples of FRAME
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_to(input int k);
        int n = 0;
        while (cyc < k && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("run_to", cyc, k);
    endtask

    // Called on the negedge where frame_start is high; counts lit clocks over the next frame
    task automatic measure(input string tag, input int er, input int eg, input int eb, input int eb_busy);
        int nr = 0, ng = 0, nb = 0;
        chk({tag, "_fs"}, frame_start, 1);
        chk({tag, "_busy"}, busy, eb_busy);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (led_r === 1'b0) nr++;
            if (led_g === 1'b0) ng++;
            if (led_b === 1'b0) nb++;
        end
        chk({tag, "_r"}, nr, er);
        chk({tag, "_g"}, ng, eg);
        chk({tag, "_b"}, nb, eb);
    endtask

    // Issue one request and check every resulting frame against the arithmetic model
    task automatic request(input string tag, input int r, input int g, input int b,
                           input bit fade, input bit at_fb);
        int t[3];
        int ka, kf, steps;
        bit done;
        t[0] = r; t[1] = g; t[2] = b;
        if (at_fb) begin
            for (int i = 0; i < 20 && (cyc % FRAME) != FRAME - 1; i++) @(negedge clk);
            chk({tag, "_align"}, cyc % FRAME, FRAME - 1);
        end else begin
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        chk({tag, "_rdy0"}, col_ready, 1);
        col_r = PB'(r); col_g = PB'(g); col_b = PB'(b); col_fade = fade; col_valid = 1'b1;
        @(posedge clk);
        #1;
        col_valid = 1'b0;
        ka = cyc;
        kf = (ka / FRAME + 1) * FRAME;
        chk({tag, "_rdy_drop"}, col_ready, 0);
        chk({tag, "_busy_rise"}, busy, 1);
        if (ka % FRAME == 0) begin
            @(negedge clk);
            measure({tag, "_coll"}, md[0], md[1], md[2], 1);
        end else begin
            run_to(kf);
        end
        if (!fade) begin
            for (int c = 0; c < 3; c++) md[c] = t[c];
            measure({tag, "_jump"}, md[0], md[1], md[2], 0);
        end else begin
            done = 1'b0;
            steps = 0;
            while (!done && steps < 20) begin
                for (int c = 0; c < 3; c++) begin
                    if (md[c] < t[c]) md[c]++;
                    else if (md[c] > t[c]) md[c]--;
                end
                done = (md[0] == t[0]) && (md[1] == t[1]) && (md[2] == t[2]);
                steps++;
                measure($sformatf("%s_fade%0d", tag, steps), md[0], md[1], md[2], done ? 0 : 1);
            end
        end
        chk({tag, "_rdy_end"}, col_ready, 1);
    endtask

    initial begin
        int ka, kf, klast, guard;
        int d[3];
        for (int c = 0; c < 3; c++) md[c] = 0;

        // Reset values while held and after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_led_r", led_r, 1);
        chk("rst_led_g", led_g, 1);
        chk("rst_led_b", led_b, 1);
        chk("rst_ready", col_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fs", frame_start, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_led_r", led_r, 1);
        chk("rel_busy", busy, 0);

        // Directed jump, fade up from zero, mixed fade down
        request("jump", 4, 0, 15, 1'b0, 1'b0);
        request("zero", 0, 0, 0, 1'b0, 1'b0);
        request("fadeup", 3, 0, 0, 1'b1, 1'b0);
        request("set5", 5, 0, 0, 1'b0, 1'b0);
        request("mixdn", 2, 0, 2, 1'b1, 1'b0);
        request("same", 2, 0, 2, 1'b1, 1'b0);

        // Accept on the boundary clock: that boundary must not apply it
        request("coll_j", 9, 1, 14, 1'b0, 1'b1);
        request("coll_f", 7, 3, 12, 1'b1, 1'b1);

        // Randomized jumps and fades
        for (int i = 0; i < 4; i++)
            request($sformatf("rj%0d", i), $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            request($sformatf("rf%0d", i), $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), 1'b1, 1'b0);

        // Backpressure: valid held with changing data through a three-step fade
        request("bp_zero", 0, 0, 0, 1'b0, 1'b0);
        col_r = 4'd3; col_g = 4'd0; col_b = 4'd0; col_fade = 1'b1; col_valid = 1'b1;
        @(posedge clk);
        #1;
        ka = cyc;
        kf = (ka / FRAME + 1) * FRAME;
        klast = kf + 2 * FRAME;
        guard = 0;
        @(negedge clk);
        while (cyc < klast && guard < 300) begin
            chk("bp_ready_low", col_ready, 0);
            col_r = PB'($urandom_range(0, 15));
            col_g = PB'($urandom_range(0, 15));
            col_b = PB'($urandom_range(0, 15));
            col_fade = 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
        end
        chk("bp_end_cyc", cyc, klast);
        chk("bp_ready_back", col_ready, 1);
        d[0] = $urandom_range(0, 15); d[1] = $urandom_range(0, 15); d[2] = $urandom_range(0, 15);
        col_r = PB'(d[0]); col_g = PB'(d[1]); col_b = PB'(d[2]); col_fade = 1'b0;
        @(posedge clk);
        #1;
        col_valid = 1'b0;
        chk("bp_accept", col_ready, 0);
        run_to((cyc / FRAME + 1) * FRAME);
        for (int c = 0; c < 3; c++) md[c] = d[c];
        measure("bp_data", md[0], md[1], md[2], 0);

        // Reset in the middle of a fade from full towards off
        request("full", 15, 15, 15, 1'b0, 1'b0);
        col_r = 4'd0; col_g = 4'd0; col_b = 4'd0; col_fade = 1'b1; col_valid = 1'b1;
        @(posedge clk);
        #1;
        col_valid = 1'b0;
        kf = (cyc / FRAME + 1) * FRAME;
        run_to(kf + FRAME);
        repeat (3) @(negedge clk);
        chk("midfade_lit", led_r, 0);
        chk("midfade_busy", busy, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_led_r", led_r, 1);
        chk("arst_led_g", led_g, 1);
        chk("arst_led_b", led_b, 1);
        chk("arst_ready", col_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_fs", frame_start, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) md[c] = 0;
        run_to(FRAME);
        measure("post_rst", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
